pipe_scheduler: RTL

//   Owns the pipe stream and the score for the game top: scroll position, the two on-screen
//   gap heights and the current/high score. Consumes game state, pause and the RNG byte.

---
 rtl/pipe_scheduler_pkg.sv | 46 ++++
 rtl/pipe_scheduler_if.sv | 28 ++
 rtl/pipe_scheduler_tick_divider.sv | 42 ++++
 rtl/pipe_scheduler.sv | 92 +++++++++
 4 files changed

// File: rtl/pipe_scheduler_pkg.sv
// Shared game-state encodings, scroll/gap defaults and small helpers for the pipe scheduler.
// Pure declarations; no state.
package pipe_scheduler_pkg;

  localparam logic [1:0] ST_LOST  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  localparam int unsigned DEF_SCROLL_DIV = 131072;
  localparam int unsigned DEF_TRACK_LEN  = 345;
  localparam int unsigned DEF_GAP_MIN    = 20;
  localparam int unsigned DEF_GAP_MAX    = 180;
  localparam int unsigned DEF_RESET_GAP  = 100;

  typedef enum logic [1:0] {
    MODE_FROZEN = 2'd0,
    MODE_RESET  = 2'd1,
    MODE_RUN    = 2'd2
  } mode_e;

  // State 3 and paused play both fall through to FROZEN.
  function automatic mode_e decode_mode(input logic [1:0] st, input logic pause);
    mode_e m;
    m = MODE_FROZEN;
    if (st == ST_RESET) begin
      m = MODE_RESET;
    end else if (st == ST_PLAY && !pause) begin
      m = MODE_RUN;
    end
    return m;
  endfunction

  function automatic logic [7:0] clamp_gap(input logic [7:0] r,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    logic [7:0] v;
    v = r;
    if (r < lo) begin
      v = lo;
    end else if (r > hi) begin
      v = hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Game-top <-> pipe scheduler bundle: game state/pause/RNG in, scroll and score view out.
// master = game top, slave = scheduler.
interface pipe_scheduler_if #(
  parameter int SCORE_W = 4
);
  logic [1:0]         state;
  logic               pause;
  logic [7:0]         random;
  logic [9:0]         pipe_pos;
  logic [7:0]         pipe_array0;
  logic [7:0]         pipe_array1;
  logic [SCORE_W-1:0] current_score;
  logic [SCORE_W-1:0] high_score;
  logic               pass_pulse;
  logic               scroll_tick;

  modport master (
    output state, pause, random,
    input  pipe_pos, pipe_array0, pipe_array1, current_score, high_score,
           pass_pulse, scroll_tick
  );

  modport slave (
    input  state, pause, random,
    output pipe_pos, pipe_array0, pipe_array1, current_score, high_score,
           pass_pulse, scroll_tick
  );
endinterface

// File: rtl/pipe_scheduler_tick_divider.sv
// Enable-gated prescaler 0..DIV-1 with synchronous clear; wrap is combinational on the
// terminal-count cycle, tick is the same event registered (high the following cycle).
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic sclr,
  output logic tick,
  output logic wrap
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    wrap   = en && !sclr && (cnt_q == CW'(DIV - 1));
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (sclr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      tick_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe scroll position, gap heights and score for the game top.
// Steps on the prescaler wrap edge; next-gap lands in pipe_array1 1 clk after the wrap cycle.
module pipe_scheduler
  import pipe_scheduler_pkg::*;
#(
  parameter int unsigned SCROLL_DIV = DEF_SCROLL_DIV,
  parameter int unsigned TRACK_LEN  = DEF_TRACK_LEN,
  parameter int unsigned GAP_MIN    = DEF_GAP_MIN,
  parameter int unsigned GAP_MAX    = DEF_GAP_MAX,
  parameter int unsigned RESET_GAP  = DEF_RESET_GAP,
  parameter int          SCORE_W    = 4
) (
  input logic              clk,
  input logic              clr_n,
  pipe_scheduler_if.slave  bus
);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  mode_e mode;
  logic  run, rst_mode, step, tick;

  logic [9:0]         pos_q, pos_d;
  logic [7:0]         a0_q, a0_d, a1_q, a1_d;
  logic [SCORE_W-1:0] cur_q, cur_d, hs_q, hs_d;
  logic               pass_q, pass_d;

  assign mode     = decode_mode(bus.state, bus.pause);
  assign run      = (mode == MODE_RUN);
  assign rst_mode = (mode == MODE_RESET);

  tick_divider #(.DIV(SCROLL_DIV)) u_div (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (run),
    .sclr  (rst_mode),
    .tick  (tick),
    .wrap  (step)
  );

  always_comb begin
    pos_d  = pos_q;
    a0_d   = a0_q;
    a1_d   = a1_q;
    cur_d  = cur_q;
    pass_d = 1'b0;
    // High score trails current score by one clock and is only cleared by clr_n.
    hs_d   = (cur_q > hs_q) ? cur_q : hs_q;
    if (rst_mode) begin
      pos_d = '0;
      a0_d  = 8'(RESET_GAP);
      a1_d  = 8'(RESET_GAP);
      cur_d = '0;
    end else if (step) begin
      if (pos_q == 10'(TRACK_LEN)) begin
        pos_d  = '0;
        a0_d   = a1_q;
        a1_d   = clamp_gap(bus.random, 8'(GAP_MIN), 8'(GAP_MAX));
        cur_d  = (cur_q == SCORE_MAX) ? cur_q : cur_q + SCORE_W'(1);
        pass_d = 1'b1;
      end else begin
        pos_d = pos_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pos_q  <= '0;
      a0_q   <= 8'(RESET_GAP);
      a1_q   <= 8'(RESET_GAP);
      cur_q  <= '0;
      hs_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      a0_q   <= a0_d;
      a1_q   <= a1_d;
      cur_q  <= cur_d;
      hs_q   <= hs_d;
      pass_q <= pass_d;
    end
  end

  assign bus.pipe_pos      = pos_q;
  assign bus.pipe_array0   = a0_q;
  assign bus.pipe_array1   = a1_q;
  assign bus.current_score = cur_q;
  assign bus.high_score    = hs_q;
  assign bus.pass_pulse    = pass_q;
  assign bus.scroll_tick   = tick;

endmodule
